acumulador_com_sinal: RTL and testbench
=======================================

Name: acumulador_com_sinal

Overview:
- Downstream consumer of the signed/unsigned adder stage. Takes its signed 8-bit result stream and accumulates BLOCK_LEN samples into a wider signed accumulator.
- Presents each block total on a valid/ready output with a per-block overflow flag.
- Adds sequencing, backpressure and overflow handling that the combinational adder lacks.

Parameters:
- ACC_W, 12, accumulator/result width in bits, signed; legal range 8..32.
- BLOCK_LEN, 8, samples per block; legal range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- limpar  in  1  synchronous clear of the block in progress and any pending result.
- entrada  in  8  signed sample, i.e. the adder's saida.
- entrada_valida  in  1  sample valid.
- entrada_pronto  out  1  block can accept a sample.
- resultado  out  ACC_W  signed block total.
- estouro  out  1  at least one overflow occurred in the reported block.
- saida_valida  out  1  resultado/estouro valid.
- saida_pronto  in  1  downstream accepts result.

Behaviour:
- Reset (rst_n low, async): state=ACUM, acc=0, cnt=0, ovf=0, resultado=0, estouro=0, saida_valida=0. entrada_pronto is combinational, so it reads 1 one cycle after release.
- States:
  - ACUM: entrada_pronto=1.
  - SAIDA: entrada_pronto=0, saida_valida=1.
- Input transfer = entrada_valida & entrada_pronto. On transfer:
  - entrada is sign-extended to ACC_W+1 bits and added to acc.
  - Overflow occurs when the two MSBs of the sum differ; ovf is set sticky for the block.
  - cnt increments.
- Block end is the transfer taken when cnt==BLOCK_LEN-1. On that same edge:
  - resultado <= new acc; estouro <= ovf|overflow-this-sample; saida_valida <= 1.
  - acc, cnt and ovf return to 0; state -> SAIDA.
- Latency: result visible the cycle after the last sample transfer.
- SAIDA: resultado and estouro are held stable. When saida_pronto=1, state -> ACUM and saida_valida <= 0. Earliest new input transfer is the following cycle.
- BLOCK_LEN=1: every accepted sample produces a result.
- limpar has priority over everything except reset:
  - Clears acc, cnt, ovf and saida_valida; state -> ACUM.
  - A sample presented in the same cycle is dropped.
  - resultado and estouro keep their last values.
- Async reset mid-block or in SAIDA clears all state immediately, without waiting for a clock edge.
- Inputs with entrada_valida=0 have no effect. entrada is don't-care while entrada_valida=0.

Optional Feature:
- Macro: ACUMULADOR_SATURACAO_EN.
- Defined: on overflow acc clamps to 2^(ACC_W-1)-1 (positive overflow) or -2^(ACC_W-1) (negative overflow). Accumulation continues from the clamped value.
- Undefined: sum is truncated to ACC_W bits (two's-complement wrap).
- estouro is reported identically in both builds.

Decomposition:
- Package acumulador_pkg holds:
  - the state enum {ACUM, SAIDA};
  - localparam helpers for the ACC_W max/min constants;
  - the cnt width as $clog2(BLOCK_LEN+1).
- One sub-module, soma_saturada: combinational ACC_W-wide add of acc plus sign-extended sample. Outputs are sum and overflow. Clamp vs wrap is selected by ACUMULADOR_SATURACAO_EN.

Test Plan:
- Reset: hold rst_n=0 -> all outputs 0. First cycle after release -> entrada_pronto=1.
- ACC_W=12, BLOCK_LEN=4: samples 10, -3, 127, -128 on consecutive cycles -> next cycle resultado=6, estouro=0, saida_valida=1.
- Backpressure: hold saida_pronto=0 for 5 cycles after a result while driving entrada_valida=1 -> resultado held, entrada_pronto=0, no sample absorbed. Then saida_pronto=1 -> saida_valida=0 next cycle and entrada_pronto=1.
- ACC_W=8, BLOCK_LEN=4: samples 100, 100, -50, 10 -> with macro resultado=87, estouro=1; without macro resultado=-96, estouro=1.
- limpar after 2 samples (5, 5), then samples 1, 2, 3, 4 (BLOCK_LEN=4) -> resultado=10, estouro=0. limpar asserted together with a sample -> that sample is dropped.
- Assert rst_n=0 between clock edges while saida_valida=1 -> saida_valida=0 immediately. After release the next block totals from 0.

Source files
------------

// File: rtl/acumulador_com_sinal_pkg.sv
// Shared types and constant helpers for the signed block accumulator.
// Optional build macro: ACUMULADOR_SATURACAO_EN (clamp on overflow instead of wrap).
package acumulador_pkg;

    // Width of the incoming sample (the adder stage result).
    localparam int AMOSTRA_W = 8;

    // ACUM: absorbing samples; SAIDA: holding a block total for downstream.
    typedef enum logic {
        ACUM  = 1'b0,
        SAIDA = 1'b1
    } estado_t;

    // Bit pattern of the largest positive value of a w-bit signed number.
    function automatic logic [31:0] acc_max_bits(input int w);
        return (32'h1 << (w - 1)) - 32'h1;
    endfunction

    // Bit pattern of the most negative value of a w-bit signed number.
    function automatic logic [31:0] acc_min_bits(input int w);
        return 32'h1 << (w - 1);
    endfunction

    // Width of the sample counter for a block of len samples.
    function automatic int cnt_w(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/acumulador_com_sinal_if.sv
// Sample-in / block-total-out handshake bundle of the block accumulator.
// master: upstream sample source and downstream result consumer.
// slave : the accumulator itself.
interface acumulador_com_sinal_if
    import acumulador_pkg::*;
#(
    parameter int ACC_W = 12
);
    logic                        limpar;
    logic signed [AMOSTRA_W-1:0] entrada;
    logic                        entrada_valida;
    logic                        entrada_pronto;
    logic signed [ACC_W-1:0]     resultado;
    logic                        estouro;
    logic                        saida_valida;
    logic                        saida_pronto;

    modport master (
        output limpar, entrada, entrada_valida, saida_pronto,
        input  entrada_pronto, resultado, estouro, saida_valida
    );

    modport slave (
        input  limpar, entrada, entrada_valida, saida_pronto,
        output entrada_pronto, resultado, estouro, saida_valida
    );
endinterface

// File: rtl/acumulador_com_sinal_soma.sv
// soma_saturada: combinational acc + sign-extended sample with overflow flag.
// Build macro ACUMULADOR_SATURACAO_EN selects clamp-on-overflow; otherwise the
// sum wraps in two's complement. The overflow flag is identical in both builds.
module soma_saturada
    import acumulador_pkg::*;
#(
    parameter int ACC_W = 12
) (
    input  logic signed [ACC_W-1:0]     acc,
    input  logic signed [AMOSTRA_W-1:0] amostra,
    output logic signed [ACC_W-1:0]     soma,
    output logic                        estouro
);
    // One guard bit: the two MSBs disagree exactly when the ACC_W result overflowed.
    logic [ACC_W:0] soma_larga;

    assign soma_larga = {acc[ACC_W-1], acc}
                      + {{(ACC_W + 1 - AMOSTRA_W){amostra[AMOSTRA_W-1]}}, amostra};
    assign estouro    = soma_larga[ACC_W] ^ soma_larga[ACC_W-1];

`ifdef ACUMULADOR_SATURACAO_EN
    localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(acc_max_bits(ACC_W));
    localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(acc_min_bits(ACC_W));

    // Clamp toward the true sign of the sum, held in the guard bit.
    always_comb begin
        soma = soma_larga[ACC_W-1:0];
        if (estouro) begin
            soma = soma_larga[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end
`else
    assign soma = soma_larga[ACC_W-1:0];
`endif
endmodule

// File: rtl/acumulador_com_sinal.sv
// acumulador_com_sinal: sums BLOCK_LEN signed samples into an ACC_W-bit total,
// presented on a valid/ready output with a sticky per-block overflow flag.
// Build macro ACUMULADOR_SATURACAO_EN: saturate instead of wrap on overflow.
module acumulador_com_sinal
    import acumulador_pkg::*;
#(
    parameter int ACC_W     = 12,
    parameter int BLOCK_LEN = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    acumulador_com_sinal_if.slave bus
);
    localparam int               CNT_W  = cnt_w(BLOCK_LEN);
    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(BLOCK_LEN - 1);

    estado_t                 estado, prox_estado;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] soma;
    logic [CNT_W-1:0]        cnt;
    logic                    ovf;
    logic                    ovf_amostra;
    logic                    pronto;
    logic                    transferencia;
    logic                    fim_bloco;
    logic signed [ACC_W-1:0] resultado_q;
    logic                    estouro_q;

    soma_saturada #(.ACC_W(ACC_W)) u_soma (
        .acc     (acc),
        .amostra (bus.entrada),
        .soma    (soma),
        .estouro (ovf_amostra)
    );

    // Held low during reset so every output reads 0 while rst_n is asserted.
    assign pronto        = rst_n && (estado == ACUM);
    assign transferencia = bus.entrada_valida && pronto;
    assign fim_bloco     = transferencia && (cnt == ULTIMO);

    assign bus.entrada_pronto = pronto;
    assign bus.saida_valida   = (estado == SAIDA);
    assign bus.resultado      = resultado_q;
    assign bus.estouro        = estouro_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) estado <= ACUM;
        else        estado <= prox_estado;
    end

    // Next state: limpar forces ACUM; otherwise block end enters SAIDA, ready leaves it.
    always_comb begin
        // NOTE: default first so no path leaves prox_estado unassigned (no latch).
        prox_estado = estado;
        if (bus.limpar) begin
            prox_estado = ACUM;
        end else begin
            case (estado)
                ACUM:    if (fim_bloco)        prox_estado = SAIDA;
                SAIDA:   if (bus.saida_pronto) prox_estado = ACUM;
                default:                       prox_estado = ACUM;
            endcase
        end
    end

    // Accumulate accepted samples; latch total and overflow at block end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: result registers are reset too, so resultado reads 0 before the first block.
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            resultado_q <= '0;
            estouro_q   <= 1'b0;
        end else if (bus.limpar) begin
            // Drops the block in progress (and any same-cycle sample); last result is kept.
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (transferencia) begin
            if (fim_bloco) begin
                resultado_q <= soma;
                estouro_q   <= ovf | ovf_amostra;
                acc         <= '0;
                cnt         <= '0;
                ovf         <= 1'b0;
            end else begin
                acc <= soma;
                cnt <= cnt + CNT_W'(1);
                ovf <= ovf | ovf_amostra;
            end
        end
    end
endmodule

// File: tb/tb_acumulador_com_sinal.sv
// Bench for acumulador_com_sinal: three instances (12-bit/4, 8-bit/4, 8-bit/1)
// driven by directed and randomized scenarios against a behavioural block model.
// Honours ACUMULADOR_SATURACAO_EN the same way the design does.
module tb_acumulador_com_sinal;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    acumulador_com_sinal_if #(.ACC_W(12)) ba ();
    acumulador_com_sinal_if #(.ACC_W(8))  bb ();
    acumulador_com_sinal_if #(.ACC_W(8))  bc ();

    acumulador_com_sinal #(.ACC_W(12), .BLOCK_LEN(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ba));
    acumulador_com_sinal #(.ACC_W(8),  .BLOCK_LEN(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bb));
    acumulador_com_sinal #(.ACC_W(8),  .BLOCK_LEN(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bc));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Block total from plain integer arithmetic: sum sample by sample, any
    // partial sum outside the w-bit signed range is an overflow, then clamp or wrap.
    function automatic void modelo(input int w, input int q[$], output int res, output bit ov);
        int maxv, minv, acc, s;
        maxv = (1 << (w - 1)) - 1;
        minv = -(1 << (w - 1));
        acc  = 0;
        ov   = 1'b0;
        foreach (q[i]) begin
            s = acc + q[i];
            if (s > maxv || s < minv) begin
                ov = 1'b1;
`ifdef ACUMULADOR_SATURACAO_EN
                s = (s > maxv) ? maxv : minv;
`else
                s = (s > maxv) ? s - (1 << w) : s + (1 << w);
`endif
            end
            acc = s;
        end
        res = acc;
    endfunction

    task automatic enviar_a(input int q[$]);
        foreach (q[i]) begin
            ba.entrada_valida = 1'b1;
            ba.entrada        = 8'(q[i]);
            tick();
        end
        ba.entrada_valida = 1'b0;
        ba.entrada        = 8'($urandom);
    endtask

    task automatic enviar_b(input int q[$]);
        foreach (q[i]) begin
            bb.entrada_valida = 1'b1;
            bb.entrada        = 8'(q[i]);
            tick();
        end
        bb.entrada_valida = 1'b0;
        bb.entrada        = 8'($urandom);
    endtask

    task automatic liberar_a();
        ba.saida_pronto = 1'b1;
        tick();
        ba.saida_pronto = 1'b0;
    endtask

    task automatic liberar_b();
        bb.saida_pronto = 1'b1;
        tick();
        bb.saida_pronto = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        tick();
        tick();
        total++; if (ba.saida_valida !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", ba.saida_valida); end
        total++; if (ba.resultado !== 12'sd0) begin bad++; $display("FAIL reset_resultado: got %0d want 0", ba.resultado); end
        total++; if (ba.estouro !== 1'b0) begin bad++; $display("FAIL reset_estouro: got %b want 0", ba.estouro); end
        total++; if (ba.entrada_pronto !== 1'b0) begin bad++; $display("FAIL reset_pronto: got %b want 0", ba.entrada_pronto); end
        total++; if (bb.resultado !== 8'sd0) begin bad++; $display("FAIL reset_resultado_b: got %0d want 0", bb.resultado); end
        rst_n = 1'b1;
        tick();
        total++; if (ba.entrada_pronto !== 1'b1) begin bad++; $display("FAIL pos_reset_pronto: got %b want 1", ba.entrada_pronto); end
        total++; if (bb.entrada_pronto !== 1'b1) begin bad++; $display("FAIL pos_reset_pronto_b: got %b want 1", bb.entrada_pronto); end
    endtask

    task automatic test_soma_basica();
        enviar_a('{10, -3, 127, -128});
        total++; if (ba.resultado !== 12'sd6) begin bad++; $display("FAIL basica_resultado: got %0d want 6", ba.resultado); end
        total++; if (ba.estouro !== 1'b0) begin bad++; $display("FAIL basica_estouro: got %b want 0", ba.estouro); end
        total++; if (ba.saida_valida !== 1'b1) begin bad++; $display("FAIL basica_valid: got %b want 1", ba.saida_valida); end
    endtask

    task automatic test_back_to_back();
        ba.entrada_valida = 1'b1;
        ba.entrada        = 8'sd55;
        ba.saida_pronto   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (ba.resultado !== 12'sd6) begin bad++; $display("FAIL bp_resultado[%0d]: got %0d want 6", i, ba.resultado); end
            total++; if (ba.entrada_pronto !== 1'b0) begin bad++; $display("FAIL bp_pronto[%0d]: got %b want 0", i, ba.entrada_pronto); end
            total++; if (ba.saida_valida !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got %b want 1", i, ba.saida_valida); end
        end
        ba.saida_pronto = 1'b1;
        tick();
        ba.saida_pronto   = 1'b0;
        ba.entrada_valida = 1'b0;
        total++; if (ba.saida_valida !== 1'b0) begin bad++; $display("FAIL bp_release_valid: got %b want 0", ba.saida_valida); end
        total++; if (ba.entrada_pronto !== 1'b1) begin bad++; $display("FAIL bp_release_pronto: got %b want 1", ba.entrada_pronto); end
        // Any sample absorbed during backpressure would corrupt this total.
        enviar_a('{1, 1, 1, 1});
        total++; if (ba.resultado !== 12'sd4) begin bad++; $display("FAIL bp_next_block: got %0d want 4", ba.resultado); end
        liberar_a();
    endtask

    task automatic test_limpar();
        enviar_a('{5, 5});
        ba.limpar = 1'b1;
        tick();
        ba.limpar = 1'b0;
        total++; if (ba.resultado !== 12'sd4) begin bad++; $display("FAIL limpar_mantem: got %0d want 4", ba.resultado); end
        enviar_a('{1, 2, 3, 4});
        total++; if (ba.resultado !== 12'sd10) begin bad++; $display("FAIL limpar_bloco: got %0d want 10", ba.resultado); end
        total++; if (ba.estouro !== 1'b0) begin bad++; $display("FAIL limpar_estouro: got %b want 0", ba.estouro); end
        // limpar while a result is pending drops saida_valida but keeps the value.
        ba.limpar = 1'b1;
        tick();
        ba.limpar = 1'b0;
        total++; if (ba.saida_valida !== 1'b0) begin bad++; $display("FAIL limpar_saida_valid: got %b want 0", ba.saida_valida); end
        total++; if (ba.resultado !== 12'sd10) begin bad++; $display("FAIL limpar_saida_res: got %0d want 10", ba.resultado); end
        // limpar together with a sample: the sample must not enter the next block.
        enviar_a('{7, 7});
        ba.limpar         = 1'b1;
        ba.entrada_valida = 1'b1;
        ba.entrada        = 8'sd100;
        tick();
        ba.limpar         = 1'b0;
        ba.entrada_valida = 1'b0;
        enviar_a('{3, 4, 5, 6});
        total++; if (ba.resultado !== 12'sd18) begin bad++; $display("FAIL limpar_descarta: got %0d want 18", ba.resultado); end
        total++; if (ba.saida_valida !== 1'b1) begin bad++; $display("FAIL limpar_descarta_valid: got %b want 1", ba.saida_valida); end
        liberar_a();
    endtask

    task automatic test_saturacao();
        int esperado;
        enviar_b('{100, 100, -50, 10});
`ifdef ACUMULADOR_SATURACAO_EN
        esperado = 87;
`else
        esperado = -96;
`endif
        total++; if (int'(bb.resultado) !== esperado) begin bad++; $display("FAIL sat_resultado: got %0d want %0d", bb.resultado, esperado); end
        total++; if (bb.estouro !== 1'b1) begin bad++; $display("FAIL sat_estouro: got %b want 1", bb.estouro); end
        liberar_b();
    endtask

    task automatic test_reset_async();
        enviar_a('{1, 2, 3, 4});
        total++; if (ba.saida_valida !== 1'b1) begin bad++; $display("FAIL async_pre_valid: got %b want 1", ba.saida_valida); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (ba.saida_valida !== 1'b0) begin bad++; $display("FAIL async_valid: got %b want 0", ba.saida_valida); end
        total++; if (ba.resultado !== 12'sd0) begin bad++; $display("FAIL async_resultado: got %0d want 0", ba.resultado); end
        tick();
        rst_n = 1'b1;
        enviar_a('{2, 2, 2, 2});
        total++; if (ba.resultado !== 12'sd8) begin bad++; $display("FAIL async_next_block: got %0d want 8", ba.resultado); end
        liberar_a();
    endtask

    task automatic test_bloco_unitario();
        int x;
        bc.saida_pronto = 1'b1;
        for (int i = 0; i < 6; i++) begin
            x = int'($urandom_range(0, 255)) - 128;
            bc.entrada_valida = 1'b1;
            bc.entrada        = 8'(x);
            tick();
            bc.entrada_valida = 1'b0;
            total++; if (int'(bc.resultado) !== x || bc.saida_valida !== 1'b1) begin bad++; $display("FAIL unit_resultado[%0d]: got %0d/%b want %0d/1", i, bc.resultado, bc.saida_valida, x); end
            total++; if (bc.estouro !== 1'b0) begin bad++; $display("FAIL unit_estouro[%0d]: got %b want 0", i, bc.estouro); end
            tick();
            total++; if (bc.saida_valida !== 1'b0) begin bad++; $display("FAIL unit_release[%0d]: got %b want 0", i, bc.saida_valida); end
        end
        bc.saida_pronto = 1'b0;
    endtask

    task automatic test_aleatorio();
        int q[$];
        int x, res;
        bit ov;
        for (int b = 0; b < 40; b++) begin
            q.delete();
            for (int i = 0; i < 4; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    bb.entrada_valida = 1'b0;
                    bb.entrada        = 8'($urandom);
                    tick();
                end
                x = int'($urandom_range(0, 255)) - 128;
                q.push_back(x);
                bb.entrada_valida = 1'b1;
                bb.entrada        = 8'(x);
                tick();
            end
            bb.entrada_valida = 1'b0;
            modelo(8, q, res, ov);
            total++; if (int'(bb.resultado) !== res) begin bad++; $display("FAIL rand_resultado[%0d]: got %0d want %0d", b, bb.resultado, res); end
            total++; if (bb.estouro !== ov) begin bad++; $display("FAIL rand_estouro[%0d]: got %b want %b", b, bb.estouro, ov); end
            total++; if (bb.saida_valida !== 1'b1) begin bad++; $display("FAIL rand_valid[%0d]: got %b want 1", b, bb.saida_valida); end
            repeat ($urandom_range(0, 3)) begin
                bb.entrada_valida = 1'b1;
                bb.entrada        = 8'($urandom);
                tick();
                total++; if (bb.entrada_pronto !== 1'b0) begin bad++; $display("FAIL rand_bp_pronto[%0d]: got %b want 0", b, bb.entrada_pronto); end
            end
            bb.entrada_valida = 1'b0;
            liberar_b();
        end
    endtask

    initial begin
        ba.limpar = 1'b0; ba.entrada = '0; ba.entrada_valida = 1'b0; ba.saida_pronto = 1'b0;
        bb.limpar = 1'b0; bb.entrada = '0; bb.entrada_valida = 1'b0; bb.saida_pronto = 1'b0;
        bc.limpar = 1'b0; bc.entrada = '0; bc.entrada_valida = 1'b0; bc.saida_pronto = 1'b0;
        test_reset();
        test_soma_basica();
        test_back_to_back();
        test_limpar();
        test_saturacao();
        test_reset_async();
        test_bloco_unitario();
        test_aleatorio();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
